// File: rtl/ceyloniac_alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU among NUM_REQ requesters.
// Optional build macro: CEYLONIAC_ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module ceyloniac_alu_arbiter #(
   parameter int ALU_DATA_WIDTH = 32,
   parameter int ALU_OP_WIDTH   = 4,
   parameter int NUM_REQ        = 4,
   parameter int ALU_LATENCY    = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*ALU_OP_WIDTH-1:0]   req_op,
   input  logic [NUM_REQ*ALU_DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*ALU_DATA_WIDTH-1:0] req_b,
   output logic                              alu_start,
   output logic [ALU_OP_WIDTH-1:0]           alu_op,
   output logic [ALU_DATA_WIDTH-1:0]         alu_a,
   output logic [ALU_DATA_WIDTH-1:0]         alu_b,
   input  logic [ALU_DATA_WIDTH-1:0]         alu_result,
   output logic [NUM_REQ-1:0]                resp_valid,
   input  logic [NUM_REQ-1:0]                resp_ready,
   output logic [ALU_DATA_WIDTH-1:0]         resp_data,
   output logic                              busy,
   output logic [1:0]                        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; the sender holds valid and payload stable until that edge.

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   winner;
   logic               found;
   logic [3:0]         lat_cnt;
   logic               req_hs;
   logic [NUM_REQ-1:0] owner_onehot;

`ifdef CEYLONIAC_ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[IDX_W'(k)]) begin
            winner = IDX_W'(k);
            found  = 1'b1;
         end
      end
   end
`else
   logic [IDX_W-1:0] last_grant;

   // Search starts just after the previous winner so every requester gets a turn.
   always_comb begin
      int               idx;
      logic [IDX_W-1:0] cand;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx  = (int'(last_grant) + k) % NUM_REQ;
         cand = IDX_W'(idx);
         if (!found && req_valid[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      req_ready = '0;
      if (reset && (state == S_IDLE) && found)
         req_ready[winner] = 1'b1;
   end

   always_comb begin
      owner_onehot        = '0;
      owner_onehot[owner] = 1'b1;
   end

   assign req_hs    = reset && (state == S_IDLE) && found;
   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

   // The latency count is loaded at the handshake so that the ISSUE cycle is the
   // first counted cycle; the result is sampled on the cycle the count reads 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         owner      <= '0;
         lat_cnt    <= '0;
         alu_start  <= 1'b0;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
`ifndef CEYLONIAC_ALU_ARB_FIXED_PRIO_EN
         last_grant <= IDX_W'(NUM_REQ - 1);
`endif
      end else begin
         alu_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_hs) begin
                  alu_op     <= req_op[int'(winner)*ALU_OP_WIDTH +: ALU_OP_WIDTH];
                  alu_a      <= req_a[int'(winner)*ALU_DATA_WIDTH +: ALU_DATA_WIDTH];
                  alu_b      <= req_b[int'(winner)*ALU_DATA_WIDTH +: ALU_DATA_WIDTH];
                  owner      <= winner;
`ifndef CEYLONIAC_ALU_ARB_FIXED_PRIO_EN
                  last_grant <= winner;
`endif
                  lat_cnt    <= 4'(ALU_LATENCY);
                  alu_start  <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE, S_WAIT: begin
               if (lat_cnt == 4'd1) begin
                  resp_data  <= alu_result;
                  resp_valid <= owner_onehot;
                  lat_cnt    <= '0;
                  state      <= S_RESP;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
                  state   <= S_WAIT;
               end
            end
            S_RESP: begin
               if (resp_ready[owner]) begin
                  resp_valid <= '0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
